// File: rtl/mismatch_scoreboard_pkg.sv
// Shared types and default widths for the reference-vs-DUT mismatch scoreboard.
package mismatch_scoreboard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int CNT_W_DEF  = 16;
  localparam int TIME_W_DEF = 32;

endpackage

// File: rtl/mismatch_scoreboard_sat_counter.sv
// Saturating up-counter: clear has priority over increment, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc)
      q <= sat_inc(q);
  end

endmodule

// File: rtl/mismatch_scoreboard.sv
// Scoreboard comparing reference and DUT dout/out_n each RUN cycle, with a
// valid/ready report of saturating mismatch statistics at the end of a run.
module mismatch_scoreboard
  import mismatch_scoreboard_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              ref_dout,
  input  logic              dut_dout,
  input  logic              ref_out_n,
  input  logic              dut_out_n,
  output logic              mismatch,
  output logic [CNT_W-1:0]  samples,
  output logic [CNT_W-1:0]  err_dout,
  output logic [CNT_W-1:0]  err_out_n,
  output logic [CNT_W-1:0]  err_total,
  output logic              first_err_valid,
  output logic [TIME_W-1:0] first_err_time,
  output logic              busy,
  output logic              rpt_valid,
  input  logic              rpt_ready
);

  state_t            state, state_nxt;
  logic              run, clr;
  logic              m_d, m_n, any;
  logic [TIME_W-1:0] cyc;

  always_ff @(posedge clk) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = RUN;
      RUN:     if (stop)      state_nxt = REPORT;
      REPORT:  if (rpt_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign run       = (state == RUN);
  assign clr       = (state == IDLE) && start;
  assign busy      = run;
  assign rpt_valid = (state == REPORT);

  assign m_d = ref_dout ^ dut_dout;
  assign m_n = ref_out_n ^ dut_out_n;
  assign any = m_d | m_n;

  sat_counter #(.W(CNT_W)) u_samples (
    .clk(clk), .resetn(resetn), .clr(clr), .inc(run), .q(samples)
  );

  sat_counter #(.W(CNT_W)) u_err_dout (
    .clk(clk), .resetn(resetn), .clr(clr), .inc(run & m_d), .q(err_dout)
  );

  sat_counter #(.W(CNT_W)) u_err_out_n (
    .clk(clk), .resetn(resetn), .clr(clr), .inc(run & m_n), .q(err_out_n)
  );

  sat_counter #(.W(CNT_W)) u_err_total (
    .clk(clk), .resetn(resetn), .clr(clr), .inc(run & any), .q(err_total)
  );

  // Run-relative cycle index; saturates so a very long run still timestamps.
  sat_counter #(.W(TIME_W)) u_cyc (
    .clk(clk), .resetn(resetn), .clr(clr), .inc(run), .q(cyc)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      first_err_valid <= 1'b0;
      first_err_time  <= '0;
    end else if (clr) begin
      first_err_valid <= 1'b0;
      first_err_time  <= '0;
    end else if (run && any && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_time  <= cyc;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      mismatch <= 1'b0;
    else
      mismatch <= run & any;
  end

endmodule

// File: tb/tb_mismatch_scoreboard.sv
// Directed bench for mismatch_scoreboard: default widths plus a CNT_W=4 copy
// fed with the same stimulus to exercise counter saturation.
module tb_mismatch_scoreboard;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0, stop = 1'b0, rpt_ready = 1'b0;
  logic ref_dout = 1'b0, dut_dout = 1'b0, ref_out_n = 1'b0, dut_out_n = 1'b0;

  logic        mismatch, first_err_valid, busy, rpt_valid;
  logic [15:0] samples, err_dout, err_out_n, err_total;
  logic [31:0] first_err_time;

  logic        mismatch_s, first_err_valid_s, busy_s, rpt_valid_s;
  logic [3:0]  samples_s, err_dout_s, err_out_n_s, err_total_s;
  logic [31:0] first_err_time_s;

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] mm;

  always #5 clk = ~clk;

  mismatch_scoreboard dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .ref_dout(ref_dout), .dut_dout(dut_dout),
    .ref_out_n(ref_out_n), .dut_out_n(dut_out_n),
    .mismatch(mismatch), .samples(samples), .err_dout(err_dout),
    .err_out_n(err_out_n), .err_total(err_total),
    .first_err_valid(first_err_valid), .first_err_time(first_err_time),
    .busy(busy), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready)
  );

  mismatch_scoreboard #(.CNT_W(4), .TIME_W(32)) dut_s (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .ref_dout(ref_dout), .dut_dout(dut_dout),
    .ref_out_n(ref_out_n), .dut_out_n(dut_out_n),
    .mismatch(mismatch_s), .samples(samples_s), .err_dout(err_dout_s),
    .err_out_n(err_out_n_s), .err_total(err_total_s),
    .first_err_valid(first_err_valid_s), .first_err_time(first_err_time_s),
    .busy(busy_s), .rpt_valid(rpt_valid_s), .rpt_ready(rpt_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n RUN cycles sweeping ref over a..d; fd/fn flip the DUT bits per cycle,
  // stop is raised on the last cycle, mismatch is sampled after each edge.
  task automatic run_cycles(input int n, input logic [19:0] fd, input logic [19:0] fn,
                            output logic [19:0] mm_o);
    mm_o = '0;
    for (int i = 0; i < n; i++) begin
      ref_dout  = i[0];
      ref_out_n = i[1];
      dut_dout  = i[0] ^ fd[i];
      dut_out_n = i[1] ^ fn[i];
      stop      = (i == n - 1);
      tick();
      mm_o[i] = mismatch;
    end
    stop = 1'b0;
    dut_dout  = ref_dout;
    dut_out_n = ref_out_n;
  endtask

  initial begin
    // Test 1: reset, clean 20-cycle run, report held 2 cycles
    tick();
    check("rst_samples", samples, 0);
    check("rst_busy", busy, 0);
    check("rst_rpt_valid", rpt_valid, 0);
    check("rst_first_err_valid", first_err_valid, 0);
    check("rst_mismatch", mismatch, 0);
    resetn = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_samples_start", samples, 0);
    run_cycles(20, 20'h0, 20'h0, mm);
    check("t1_mm_mask", mm, 20'h0);
    check("t1_rpt_valid", rpt_valid, 1);
    check("t1_samples", samples, 20);
    check("t1_err_total", err_total, 0);
    check("t1_err_dout", err_dout, 0);
    check("t1_first_err_valid", first_err_valid, 0);
    tick();
    check("t1_rpt_valid_hold", rpt_valid, 1);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    check("t1_rpt_valid_done", rpt_valid, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_samples_hold", samples, 20);

    // Test 2: dout flip at 5, out_n flips at 5 and 9
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_start_clear", samples, 0);
    run_cycles(20, 20'h00020, 20'h00220, mm);
    check("t2_mm_mask", mm, 20'h00220);
    check("t2_err_dout", err_dout, 1);
    check("t2_err_out_n", err_out_n, 2);
    check("t2_err_total", err_total, 2);
    check("t2_first_err_valid", first_err_valid, 1);
    check("t2_first_err_time", first_err_time, 5);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;

    // Test 3: all mismatching, CNT_W=4 copy saturates at 15
    start = 1'b1;
    tick();
    start = 1'b0;
    run_cycles(20, 20'hFFFFF, 20'hFFFFF, mm);
    check("t3_s_samples", samples_s, 15);
    check("t3_s_err_dout", err_dout_s, 15);
    check("t3_s_err_out_n", err_out_n_s, 15);
    check("t3_s_err_total", err_total_s, 15);
    check("t3_s_first_err_time", first_err_time_s, 0);
    check("t3_s_rpt_valid", rpt_valid_s, 1);
    check("t3_err_total_wide", err_total, 20);
    check("t3_mm_mask", mm, 20'hFFFFF);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;

    // Test 4: start+stop together, stop cycle sample counted
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("t4_busy", busy, 1);
    check("t4_rpt_valid_idle", rpt_valid, 0);
    run_cycles(3, 20'h0, 20'h4, mm);
    check("t4_rpt_valid", rpt_valid, 1);
    check("t4_samples", samples, 3);
    check("t4_err_out_n", err_out_n, 1);
    check("t4_err_dout", err_dout, 0);
    check("t4_first_err_time", first_err_time, 2);

    // Test 5: start ignored in REPORT, then reset mid-REPORT
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_rpt_valid_hold", rpt_valid, 1);
    check("t5_samples_frozen", samples, 3);
    check("t5_busy", busy, 0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("t5_rst_rpt_valid", rpt_valid, 0);
    check("t5_rst_samples", samples, 0);
    check("t5_rst_err_out_n", err_out_n, 0);
    check("t5_rst_first_err_valid", first_err_valid, 0);
    check("t5_rst_first_err_time", first_err_time, 0);

    // Test 6: rpt_ready held high, single-cycle report, restart clears
    rpt_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_cycles(3, 20'h2, 20'h0, mm);
    check("t6_rpt_valid", rpt_valid, 1);
    check("t6_err_dout", err_dout, 1);
    check("t6_first_err_time", first_err_time, 1);
    tick();
    check("t6_rpt_valid_one", rpt_valid, 0);
    check("t6_idle_hold", samples, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_clr_samples", samples, 0);
    check("t6_clr_err_dout", err_dout, 0);
    check("t6_clr_first_err_valid", first_err_valid, 0);
    check("t6_clr_first_err_time", first_err_time, 0);
    check("t6_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("t6_end_idle", rpt_valid, 0);
    rpt_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
